mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle signed multiply/divide engine. It consumes the 4-bit ALU control code produced by the ALU control decoder and executes the two codes the single-cycle ALU cannot finish in one cycle: mult (4'b0011) and div (4'b0101).
- Results go to architectural HI/LO registers. The pipeline control stalls on busy and samples done.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request pulse; sampled only in IDLE.
- alu_con  in  4  ALU control code; acted on only when it equals 4'b0011 or 4'b0101.
- op_a  in  WIDTH  multiplicand or dividend, two's complement.
- op_b  in  WIDTH  multiplier or divisor, two's complement.
- hi_we  in  1  direct HI write (mthi).
- lo_we  in  1  direct LO write (mtlo).
- wdata  in  WIDTH  data for hi_we/lo_we.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO hold a new result.
- div_by_zero  out  1  valid with done; 1 when a div had op_b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n==0 at an edge): state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0. Reset mid-operation aborts the operation: no done pulse, HI/LO cleared.
- States and transitions:
  - IDLE: on start==1 with a mult/div code, latch the operands, the operand signs and the op type, clear the iteration count, go to CALC. A start with any other code is ignored.
  - CALC: one radix-2 step per cycle on operand magnitudes (shift-add for mult, restoring shift-subtract for div), exactly WIDTH cycles, then go to FIX.
  - FIX: apply signs and write HI/LO. done=1 for one cycle, then IDLE.
- Timing: start sampled at edge E0; busy=1 from E0 through E(WIDTH); HI/LO update and done=1 after edge E(WIDTH+1), so latency is WIDTH+1 cycles (33 by default). busy is 0 while done is 1, so a new start is accepted in the done cycle.
- Operand sampling: operands are captured at E0 only; later changes on op_a/op_b have no effect on the running operation.
- mult result: signed 2*WIDTH-bit product; HI = upper half, LO = lower half. The product is negated if exactly one operand is negative.
- div result: LO = quotient truncated toward zero, HI = remainder, with the sign of the remainder equal to the sign of the dividend.
- Most-negative dividend / -1: LO=0x80000000, HI=0, no flag.
- Divide by zero: same latency; LO=all ones, HI=op_a, div_by_zero=1 during done. The flag is cleared on the next start.
- start while busy: ignored, with no queueing.
- hi_we/lo_we:
  - In IDLE they write wdata to HI/LO at the edge.
  - If accepted together with start, the write takes effect and the result overwrites it at completion.
  - While busy they are ignored.
  - With hi_we and lo_we both set, both registers receive wdata.
- HI/LO hold their value between operations. done never asserts outside the FIX→IDLE cycle.
- Internal datapath: magnitudes are WIDTH bits unsigned, so abs(-2^31) = 2^31 is represented correctly. The accumulator/remainder is WIDTH+1 bits wide to hold the subtract borrow.

Decomposition:
- Shared package holds:
  - ALU control code constants: AND=0000, OR=0001, ADD=0010, MULT=0011, NOR=0100, DIV=0101, SUB=0110, SLT=0111, ADDU=1000, SUBU=1001, XOR=1010.
  - The state encoding (IDLE, CALC, FIX).
  - The WIDTH default.
- One natural sub-module: md_iter_step, a combinational single radix-2 step for both mult and div, selected by op type. It is instantiated once inside the FSM.

Test Plan:
- mult 7 * -3 (op_b=0xFFFFFFFD) -> after 33 cycles done=1 for one cycle, HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for the 32 preceding cycles.
- div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, div_by_zero=0.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; then div 5 / 0 -> LO=0xFFFFFFFF, HI=5, div_by_zero=1.
- Ignored requests: start with code 0010 -> no busy; second start at cycle 10 of a mult -> ignored, single done at cycle 33; hi_we with wdata=0x1234 while busy -> HI unaffected by the write.
- rst_n=0 at cycle 10 of a div -> next cycle busy=0, HI=LO=0, no done thereafter. A new mult 0xFFFFFFFF*0xFFFFFFFF started in the done cycle of a prior op -> HI=0, LO=1.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide engine:
// ALU control codes, FSM state encoding and default operand width.
package mult_div_unit_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MULT = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_DIV  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ADDU = 4'b1000;
    localparam logic [3:0] ALU_SUBU = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_md_iter_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide, chosen by is_div.
module md_iter_step
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   acc_next_c,
    output logic [WIDTH-1:0] q_next_c
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum        = acc + (WIDTH+1)'(m);
        shifted    = {acc[WIDTH-1:0], q[WIDTH-1]};
        diff       = {1'b0, shifted} - (WIDTH+2)'(m);
        acc_next_c = acc;
        q_next_c   = q;
        if (is_div) begin
            // Borrow out of the trial subtract means the divisor did not fit: restore.
            if (diff[WIDTH+1]) begin
                acc_next_c = shifted;
                q_next_c   = {q[WIDTH-2:0], 1'b0};
            end else begin
                acc_next_c = diff[WIDTH:0];
                q_next_c   = {q[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (q[0]) begin
                acc_next_c = {1'b0, sum[WIDTH:1]};
                q_next_c   = {sum[0], q[WIDTH-1:1]};
            end else begin
                acc_next_c = {1'b0, acc[WIDTH:1]};
                q_next_c   = {acc[0], q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed mult/div engine writing architectural HI/LO.
// IDLE -> CALC (WIDTH radix-2 steps on magnitudes) -> FIX (apply signs) -> IDLE.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_con,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    md_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             is_div, is_div_d;
    logic             sa, sa_d, sb, sb_d;
    logic [WIDTH-1:0] a_raw, a_raw_d;
    logic [WIDTH-1:0] m, m_d;
    logic [WIDTH:0]   acc, acc_d;
    logic [WIDTH-1:0] q, q_d;
    logic             busy_d, done_d, dbz_d;
    logic [WIDTH-1:0] hi_d, lo_d;

    logic [WIDTH:0]     acc_step;
    logic [WIDTH-1:0]   q_step;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               accept;

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (is_div),
        .acc        (acc),
        .q          (q),
        .m          (m),
        .acc_next_c (acc_step),
        .q_next_c   (q_step)
    );

    assign a_mag    = op_a[WIDTH-1] ? -op_a : op_a;
    assign b_mag    = op_b[WIDTH-1] ? -op_b : op_b;
    assign accept   = start && (alu_con == ALU_MULT || alu_con == ALU_DIV);
    assign prod_mag = {acc[WIDTH-1:0], q};
    assign prod     = (sa ^ sb) ? -prod_mag : prod_mag;
    assign quo      = (sa ^ sb) ? -q : q;
    assign rem      = sa ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            a_raw       <= '0;
            m           <= '0;
            acc         <= '0;
            q           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            is_div      <= is_div_d;
            sa          <= sa_d;
            sb          <= sb_d;
            a_raw       <= a_raw_d;
            m           <= m_d;
            acc         <= acc_d;
            q           <= q_d;
            busy        <= busy_d;
            done        <= done_d;
            div_by_zero <= dbz_d;
            hi          <= hi_d;
            lo          <= lo_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        is_div_d = is_div;
        sa_d     = sa;
        sb_d     = sb;
        a_raw_d  = a_raw;
        m_d      = m;
        acc_d    = acc;
        q_d      = q;
        done_d   = 1'b0;
        dbz_d    = div_by_zero;
        hi_d     = hi;
        lo_d     = lo;
        case (state)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (accept) begin
                    is_div_d = (alu_con == ALU_DIV);
                    sa_d     = op_a[WIDTH-1];
                    sb_d     = op_b[WIDTH-1];
                    a_raw_d  = op_a;
                    // Divide iterates on the dividend in q; multiply iterates on the multiplier.
                    m_d      = (alu_con == ALU_DIV) ? b_mag : a_mag;
                    q_d      = (alu_con == ALU_DIV) ? a_mag : b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                q_d   = q_step;
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (!is_div) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (m == '0) begin
                    hi_d  = a_raw;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// mult/div traffic compared against a plain-arithmetic signed reference.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_con;
    logic [31:0] op_a, op_b;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_con     (alu_con),
        .op_a        (op_a),
        .op_b        (op_b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {div_by_zero, hi, lo} from signed integer arithmetic.
    function automatic logic [64:0] model(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, qq, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            return {1'b0, p[63:0]};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, rr[31:0], qq[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return 32'(0 - $urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    // mode: 0 plain, 1 extra start at cycle 10, 2 hi_we at cycle 10, 3 hi/lo write with start.
    task automatic do_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [64:0] exp;
        logic [31:0] wd, hi_prev;
        int n, busy_low;
        bit got;
        exp = model(code == ALU_DIV, a, b);
        wd = 32'($urandom);
        start = 1'b1; alu_con = code; op_a = a; op_b = b;
        if (mode == 3) begin hi_we = 1'b1; lo_we = 1'b1; wdata = wd; end
        @(posedge clk); @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op_a = 32'($urandom); op_b = 32'($urandom);
        check("busy_e0", 64'(busy), 64'd1);
        check("dbz_clr", 64'(div_by_zero), 64'd0);
        if (mode == 3) begin
            check("hi_wr_start", 64'(hi), 64'(wd));
            check("lo_wr_start", 64'(lo), 64'(wd));
        end
        hi_prev = hi;
        n = 0; busy_low = 0; got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clk); n++; @(negedge clk);
            start = 1'b0; hi_we = 1'b0;
            if (done) got = 1'b1;
            else begin
                if (!busy) busy_low++;
                if (mode == 2 && n == 11) check("hi_busy_wr", 64'(hi), 64'(hi_prev));
                if (n == 10 && mode == 1) begin
                    start = 1'b1; alu_con = ALU_MULT; op_a = 32'($urandom); op_b = 32'($urandom);
                end
                if (n == 10 && mode == 2) begin hi_we = 1'b1; wdata = 32'h1234; end
            end
        end
        check("got_done", 64'(got), 64'd1);
        check("latency", 64'(n), 64'd33);
        check("busy_held", 64'(busy_low), 64'd0);
        check("busy_in_done", 64'(busy), 64'd0);
        check("hi", 64'(hi), 64'(exp[63:32]));
        check("lo", 64'(lo), 64'(exp[31:0]));
        check("dbz", 64'(div_by_zero), 64'(exp[64]));
    endtask

    task automatic idle_check(input int cycles);
        logic [31:0] h, l;
        h = hi; l = lo;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); @(negedge clk);
            check("idle_done", 64'(done), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end
        check("hold_hi", 64'(hi), 64'(h));
        check("hold_lo", 64'(lo), 64'(l));
    endtask

    initial begin
        logic [31:0] h, l;
        int dcount;
        rst_n = 1'b0; start = 1'b0; alu_con = 4'd0; op_a = '0; op_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);

        do_op(ALU_MULT, 32'd7, 32'hFFFF_FFFD, 0);
        check("m7x-3_hi", 64'(hi), 64'hFFFF_FFFF);
        check("m7x-3_lo", 64'(lo), 64'hFFFF_FFEB);
        idle_check(3);

        // Direct HI/LO writes in IDLE.
        l = lo;
        hi_we = 1'b1; wdata = 32'hCAFE_0001;
        @(posedge clk); @(negedge clk); hi_we = 1'b0;
        check("mthi", 64'(hi), 64'hCAFE_0001);
        check("mthi_lo", 64'(lo), 64'(l));
        lo_we = 1'b1; wdata = 32'hBEEF_0002;
        @(posedge clk); @(negedge clk); lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'hBEEF_0002);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_A5A5;
        @(posedge clk); @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both_hi", 64'(hi), 64'h5A5A_A5A5);
        check("mt_both_lo", 64'(lo), 64'h5A5A_A5A5);

        // Non mult/div code is ignored.
        h = hi; l = lo;
        start = 1'b1; alu_con = ALU_ADD; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk); @(negedge clk); start = 1'b0;
        check("add_busy", 64'(busy), 64'd0);
        check("add_hi", 64'(hi), 64'(h));
        check("add_lo", 64'(lo), 64'(l));
        idle_check(2);

        do_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1);
        check("d-7/2_lo", 64'(lo), 64'hFFFF_FFFD);
        check("d-7/2_hi", 64'(hi), 64'hFFFF_FFFF);
        idle_check(3);

        do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2);
        check("dmin_lo", 64'(lo), 64'h8000_0000);
        check("dmin_hi", 64'(hi), 64'd0);
        do_op(ALU_DIV, 32'd5, 32'd0, 0);
        check("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        check("dz_hi", 64'(hi), 64'd5);
        check("dz_flag", 64'(div_by_zero), 64'd1);
        do_op(ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
        check("m-1x-1_hi", 64'(hi), 64'd0);
        check("m-1x-1_lo", 64'(lo), 64'd1);
        idle_check(2);

        for (int i = 0; i < 40; i++) begin
            do_op(($urandom_range(0, 1) != 0) ? ALU_DIV : ALU_MULT, pick(), pick(), 0);
            if ($urandom_range(0, 1) != 0) idle_check(1);
        end
        idle_check(1);

        // Reset during a divide aborts it.
        start = 1'b1; alu_con = ALU_DIV; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
